mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage of the rv32i pipelined core; sits directly downstream of the EX-stage ALU.
- Consumes the ALU result as the load/store effective address, or as a plain result for non-memory ops.
- Drives a single-port data-memory request/ready handshake and generates byte enables and store lane replication.
- Formats load data (sign/zero extension) and presents a registered writeback packet; stalls upstream while an access is in flight.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in BUSY without dmem_ready before the access is aborted (1..65535).

Ports:
- clk  in  1  core clock
- r  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX stage presents a valid instruction this cycle
- op_code  in  7  instruction opcode from EX
- func3  in  3  instruction funct3 from EX
- alu_result  in  32  ALU output (effective address for loads/stores)
- store_data  in  32  rs2 value for stores
- rd_in  in  5  destination register
- mem_stall  out  1  upstream must hold EX inputs stable
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  memory completes current request (sampled only while dmem_req=1)
- dmem_rdata  in  32  read data, valid when dmem_ready=1
- wb_valid  out  1  writeback packet valid (one-cycle pulse)
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- bus_err  out  1  one-cycle pulse: access timed out (or misaligned, see feature)

Behaviour:
- Reset (async, r=1): state IDLE; mem_stall, dmem_req, dmem_we, wb_valid, bus_err = 0; dmem_addr, dmem_wdata, wb_data = 0; dmem_be = 0; wb_rd = 0; timeout counter = 0. Reset mid-access drops the request; a late dmem_ready is ignored.
- Decode: load = op_code 0000011; store = 0100011; no-writeback = store or branch (1100011).
- States: IDLE, BUSY.
- IDLE, ex_valid, load/store: register dmem_* outputs and go to BUSY. dmem_req=1 from the next cycle. Instruction fields are latched.
- IDLE, ex_valid, other op: the next cycle produces wb_valid=1 (suppressed for branches), wb_data=alu_result, wb_rd=rd_in. Throughput is 1 per cycle.
- BUSY:
  - mem_stall=1 combinationally.
  - dmem_* held constant until dmem_ready=1.
  - On dmem_ready: dmem_req falls next cycle and the block returns to IDLE. A load then pulses wb_valid with the formatted data; a store pulses nothing.
  - Minimum load latency: accept at N, ready at N+1, wb_valid at N+2.
- Timeout: the counter increments each BUSY cycle without ready. At TIMEOUT_CYCLES the request is dropped, bus_err pulses, the block returns to IDLE, and no wb_valid is produced.
- Store lanes:
  - sb (f3 000): be = 0001 << addr[1:0]; wdata = {4{sd[7:0]}}.
  - sh (001): be = addr[1] ? 1100 : 0011; wdata = {2{sd[15:0]}}.
  - sw (010): be = 1111; wdata = sd.
- Load format: select the byte/half by addr[1:0]/addr[1].
  - lb (000) / lh (001): sign-extend.
  - lbu (100) / lhu (101): zero-extend.
  - lw (010): full word.
  - Loads drive be = 1111, we = 0.
- Unknown load/store funct3 is treated as a word access.
- ex_valid arriving while BUSY is ignored; upstream is stalled and re-presents it.

Optional Feature:
- MISALIGN_TRAP_EN defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0, issues no memory request. bus_err pulses the cycle after accept, no wb_valid is produced, and the state stays IDLE.
- MISALIGN_TRAP_EN undefined: low address bits are truncated per access size (half → addr[1], word → none). The access proceeds normally and bus_err is never raised for alignment.

Test Plan:
- Non-mem pass-through: add, alu_result=0x0000_0042, rd_in=5 → next cycle wb_valid=1, wb_rd=5, wb_data=0x42, mem_stall=0, dmem_req never asserted.
- lb sign-extend: addr 0x1003, dmem_rdata=0x80FF_1234, ready 1 cycle after req → dmem_addr=0x1000, be=1111, wb_data=0xFFFF_FF80, wb_valid two cycles after accept.
- sh upper half: addr 0x2002, store_data=0x1234_ABCD → dmem_we=1, be=1100, wdata=0xABCD_ABCD, no wb_valid, mem_stall high until ready.
- Wait states: lhu addr 0x3002, ready after 5 cycles, rdata=0xBEEF_0000 → req/addr/be stable all 5 cycles, mem_stall=1 throughout, wb_data=0x0000_BEEF.
- Timeout: TIMEOUT_CYCLES=4, lw, ready never asserted → req drops after 4 BUSY cycles, bus_err single pulse, no wb_valid, next ex_valid accepted.
- Reset mid-access: assert r during BUSY, then pulse dmem_ready after release → req=0 immediately, state IDLE, no wb_valid.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage of the rv32i pipeline, directly after the EX-stage ALU.
//
// Loads and stores use alu_result as the effective address and run one request/ready
// handshake on a single-port data memory. Every other op passes alu_result straight
// through to a registered writeback packet, one per cycle.
//
// Ports
//   clk, r            core clock; asynchronous active-high reset
//   ex_valid, op_code, func3, alu_result, store_data, rd_in
//                     instruction presented by EX
//   mem_stall         high while an access is in flight; upstream holds EX stable
//   dmem_req/we/addr/wdata/be
//                     registered memory request (word address, lane-replicated data)
//   dmem_ready, dmem_rdata
//                     memory completion and read data
//   wb_valid, wb_rd, wb_data
//                     registered writeback packet (one-cycle pulse)
//   bus_err           one-cycle pulse on access timeout (or misaligned access, see below)
//
// Build option
//   MISALIGN_TRAP_EN  when defined, a misaligned half/word access issues no request and
//                     pulses bus_err instead. When undefined, low address bits are ignored
//                     according to the access size.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        r,
    input  logic        ex_valid,
    input  logic [6:0]  op_code,
    input  logic [2:0]  func3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        bus_err
);

    localparam logic [6:0]  OpLoad   = 7'b0000011;
    localparam logic [6:0]  OpStore  = 7'b0100011;
    localparam logic [6:0]  OpBranch = 7'b1100011;
    localparam logic [15:0] TmoLast  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [4:0]  rd_q, rd_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        bus_err_q, bus_err_d;

    logic        is_load, is_store, is_branch, misalign;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign is_load   = (op_code == OpLoad);
    assign is_store  = (op_code == OpStore);
    assign is_branch = (op_code == OpBranch);

`ifdef MISALIGN_TRAP_EN
    logic acc_byte, acc_half;
    // Unknown funct3 encodings fall into the word class.
    assign acc_byte = (func3 == 3'b000) || (is_load && func3 == 3'b100);
    assign acc_half = (func3 == 3'b001) || (is_load && func3 == 3'b101);
    assign misalign = acc_byte ? 1'b0 :
                      acc_half ? alu_result[0] : (alu_result[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Store lane steering; anything that is not sb/sh is a full-word store.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        case (func3)
            3'b000: begin
                st_be    = 4'b0001 << alu_result[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            3'b001: begin
                st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load formatting uses the latched funct3 and address offset.
    always_comb begin
        ld_byte = dmem_rdata[{addr_lo_q, 3'b000} +: 8];
        ld_half = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (func3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_load_d    = is_load_q;
        func3_d      = func3_q;
        addr_lo_d    = addr_lo_q;
        rd_d         = rd_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        bus_err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ex_valid) begin
                    if (is_load || is_store) begin
                        if (misalign) begin
                            bus_err_d = 1'b1;
                        end else begin
                            state_d      = StBusy;
                            cnt_d        = '0;
                            is_load_d    = is_load;
                            func3_d      = func3;
                            addr_lo_d    = alu_result[1:0];
                            rd_d         = rd_in;
                            dmem_req_d   = 1'b1;
                            dmem_we_d    = is_store;
                            dmem_addr_d  = {alu_result[31:2], 2'b00};
                            dmem_be_d    = is_store ? st_be : 4'b1111;
                            dmem_wdata_d = st_wdata;
                        end
                    end else begin
                        // Branches still update the packet fields but never assert valid.
                        wb_valid_d = ~is_branch;
                        wb_rd_d    = rd_in;
                        wb_data_d  = alu_result;
                    end
                end
            end
            StBusy: begin
                if (dmem_ready) begin
                    state_d    = StIdle;
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    if (is_load_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = ld_data;
                    end
                end else if (cnt_q == TmoLast) begin
                    state_d    = StIdle;
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    bus_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            is_load_q    <= 1'b0;
            func3_q      <= '0;
            addr_lo_q    <= '0;
            rd_q         <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_load_q    <= is_load_d;
            func3_q      <= func3_d;
            addr_lo_q    <= addr_lo_d;
            rd_q         <= rd_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign mem_stall  = (state_q == StBusy);
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_be    = dmem_be_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage (default build, MISALIGN_TRAP_EN undefined), TIMEOUT_CYCLES=4.
// A transaction-level model predicts every output cycle by cycle; directed scenarios add
// hand-computed literal expectations.
module tb_mem_access_stage;

    localparam int unsigned TMO = 4;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    logic        clk = 1'b0;
    logic        r = 1'b0;
    logic        ex_valid = 1'b0;
    logic [6:0]  op_code = '0;
    logic [2:0]  func3 = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd_in = '0;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        mem_stall, dmem_req, dmem_we, wb_valid, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .r          (r),
        .ex_valid   (ex_valid),
        .op_code    (op_code),
        .func3      (func3),
        .alu_result (alu_result),
        .store_data (store_data),
        .rd_in      (rd_in),
        .mem_stall  (mem_stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd0) return 4'(1 << a[1:0]);
        if (f3 == 3'd1) return a[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3 == 3'd0) return (sd & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdat);
        logic [31:0] b, h;
        b = (rdat >> (8 * a[1:0])) & 32'hFF;
        h = (rdat >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b ^ 32'h80) - 32'h80;
            3'd1:    return (h ^ 32'h8000) - 32'h8000;
            3'd4:    return b;
            3'd5:    return h;
            default: return rdat;
        endcase
    endfunction

    bit          m_busy = 0;
    int          m_n = 0;
    bit          m_is_ld = 0;
    logic [2:0]  m_f3 = '0;
    logic [31:0] m_addr = '0;
    logic [4:0]  m_rd = '0;
    logic        e_stall = 0, e_req = 0, e_we = 0, e_wbv = 0, e_err = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_data = '0;
    logic [3:0]  e_be = '0;
    logic [4:0]  e_rd = '0;

    task automatic model_step();
        if (r) begin
            m_busy = 0; m_n = 0;
            e_stall = 0; e_req = 0; e_we = 0; e_wbv = 0; e_err = 0;
            e_addr = '0; e_wdata = '0; e_data = '0; e_be = '0; e_rd = '0;
            return;
        end
        e_wbv = 0;
        e_err = 0;
        if (!m_busy) begin
            if (ex_valid && (op_code == OP_LOAD || op_code == OP_STORE)) begin
                m_busy  = 1;
                m_n     = 0;
                m_is_ld = (op_code == OP_LOAD);
                m_f3    = func3;
                m_addr  = alu_result;
                m_rd    = rd_in;
                e_req   = 1;
                e_we    = !m_is_ld;
                e_addr  = alu_result & 32'hFFFF_FFFC;
                e_be    = m_is_ld ? 4'hF : m_be(func3, alu_result);
                e_wdata = m_wdata(func3, store_data);
            end else if (ex_valid) begin
                e_wbv  = (op_code != OP_BRANCH);
                e_rd   = rd_in;
                e_data = alu_result;
            end
        end else if (dmem_ready) begin
            m_busy = 0;
            e_req  = 0;
            if (m_is_ld) begin
                e_wbv  = 1;
                e_rd   = m_rd;
                e_data = m_load(m_f3, m_addr, dmem_rdata);
            end
        end else begin
            m_n++;
            if (m_n == TMO) begin
                m_busy = 0;
                e_req  = 0;
                e_err  = 1;
            end
        end
        e_stall = m_busy;
    endtask

    initial forever begin
        @(posedge clk or posedge r);
        model_step();
    end

    // ---------------- compare / monitor ----------------
    int          wb_cnt = 0, err_cnt = 0, req_cyc = 0;
    logic [31:0] last_wb_data = '0, last_addr = '0, last_wdata = '0;
    logic [4:0]  last_wb_rd = '0;
    logic [3:0]  last_be = '0;
    logic        last_we = 0;

    initial forever begin
        @(negedge clk);
        chk("mem_stall", 32'(mem_stall), 32'(e_stall));
        chk("dmem_req", 32'(dmem_req), 32'(e_req));
        if (e_req) begin
            chk("dmem_we", 32'(dmem_we), 32'(e_we));
            chk("dmem_addr", dmem_addr, e_addr);
            chk("dmem_be", 32'(dmem_be), 32'(e_be));
            if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
        end
        chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
        if (e_wbv) begin
            chk("wb_rd", 32'(wb_rd), 32'(e_rd));
            chk("wb_data", wb_data, e_data);
        end
        chk("bus_err", 32'(bus_err), 32'(e_err));
        if (dmem_req) begin
            req_cyc++;
            last_addr = dmem_addr; last_be = dmem_be; last_we = dmem_we; last_wdata = dmem_wdata;
        end
        if (wb_valid) begin
            wb_cnt++;
            last_wb_data = wb_data; last_wb_rd = wb_rd;
        end
        if (bus_err) err_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd);
        ex_valid = 1; op_code = op; func3 = f3; alu_result = a; store_data = sd; rd_in = rd;
        step();
        ex_valid = 0;
    endtask

    task automatic ready_now(input logic [31:0] rdat);
        dmem_ready = 1; dmem_rdata = rdat;
        step();
        dmem_ready = 0;
    endtask

    logic [2:0]  ld_f3  [4] = '{3'd1, 3'd4, 3'd2, 3'd7};
    logic [31:0] ld_a   [4] = '{32'h0000_0006, 32'h0000_0001, 32'h0000_0008, 32'h0000_000C};
    logic [31:0] ld_rd  [4] = '{32'h8001_7FFF, 32'h0000_F200, 32'hCAFE_F00D, 32'h1357_9BDF};
    logic [31:0] ld_exp [4] = '{32'hFFFF_8001, 32'h0000_00F2, 32'hCAFE_F00D, 32'h1357_9BDF};
    logic [2:0]  st_f3  [4] = '{3'd0, 3'd2, 3'd0, 3'd3};
    logic [31:0] st_a   [4] = '{32'h0000_0011, 32'h0000_0020, 32'h0000_0013, 32'h0000_0031};
    logic [31:0] st_sd  [4] = '{32'h0000_00A5, 32'h0123_4567, 32'hFFFF_FF5A, 32'hFEED_BEEF};
    logic [3:0]  st_be  [4] = '{4'b0010, 4'b1111, 4'b1000, 4'b1111};
    logic [31:0] st_wd  [4] = '{32'hA5A5_A5A5, 32'h0123_4567, 32'h5A5A_5A5A, 32'hFEED_BEEF};

    int b_wb, b_req, b_err;

    task automatic snap();
        b_wb = wb_cnt; b_req = req_cyc; b_err = err_cnt;
    endtask

    initial begin
        #1 r = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_stall", 32'(mem_stall), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        step();
        r = 0;
        step();

        // Non-memory pass-through
        snap();
        issue(OP_ALU, 3'd0, 32'h0000_0042, 32'd0, 5'd5);
        step();
        chk("pass_wb_count", 32'(wb_cnt - b_wb), 32'd1);
        chk("pass_wb_data", last_wb_data, 32'h0000_0042);
        chk("pass_wb_rd", 32'(last_wb_rd), 32'd5);
        chk("pass_no_req", 32'(req_cyc - b_req), 32'd0);

        // Back-to-back ALU ops, then a branch that must not write back
        snap();
        issue(OP_ALU, 3'd0, 32'h0000_0100, 32'd0, 5'd6);
        issue(OP_ALU, 3'd0, 32'h0000_0200, 32'd0, 5'd7);
        issue(OP_BRANCH, 3'd0, 32'h0000_0300, 32'd0, 5'd9);
        step();
        chk("b2b_wb_count", 32'(wb_cnt - b_wb), 32'd2);
        chk("b2b_wb_data", last_wb_data, 32'h0000_0200);

        // lb sign-extend, ready on the first request cycle
        snap();
        issue(OP_LOAD, 3'd0, 32'h0000_1003, 32'd0, 5'd1);
        ready_now(32'h80FF_1234);
        step();
        chk("lb_addr", last_addr, 32'h0000_1000);
        chk("lb_be", 32'(last_be), 32'hF);
        chk("lb_wb_data", last_wb_data, 32'hFFFF_FF80);
        chk("lb_wb_rd", 32'(last_wb_rd), 32'd1);
        chk("lb_req_cycles", 32'(req_cyc - b_req), 32'd1);

        // sh upper half, two wait states
        snap();
        issue(OP_STORE, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 5'd0);
        step();
        step();
        ready_now(32'd0);
        step();
        chk("sh_we", 32'(last_we), 32'd1);
        chk("sh_be", 32'(last_be), 32'hC);
        chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh_no_wb", 32'(wb_cnt - b_wb), 32'd0);
        chk("sh_req_cycles", 32'(req_cyc - b_req), 32'd3);

        // lhu with wait states up to the timeout limit; a new op offered while busy is ignored
        snap();
        issue(OP_LOAD, 3'd5, 32'h0000_3002, 32'd0, 5'd3);
        ex_valid = 1; op_code = OP_ALU; alu_result = 32'h0000_DEAD; rd_in = 5'd12;
        repeat (TMO - 1) step();
        ready_now(32'hBEEF_0000);
        ex_valid = 0;
        step();
        chk("lhu_req_cycles", 32'(req_cyc - b_req), 32'(TMO));
        chk("lhu_wb_count", 32'(wb_cnt - b_wb), 32'd1);
        chk("lhu_wb_data", last_wb_data, 32'h0000_BEEF);
        chk("lhu_wb_rd", 32'(last_wb_rd), 32'd3);
        chk("lhu_no_err", 32'(err_cnt - b_err), 32'd0);

        // Other load formats
        for (int i = 0; i < 4; i++) begin
            issue(OP_LOAD, ld_f3[i], ld_a[i], 32'd0, 5'(20 + i));
            ready_now(ld_rd[i]);
            step();
            chk("ld_table_data", last_wb_data, ld_exp[i]);
        end

        // Store lanes
        for (int i = 0; i < 4; i++) begin
            snap();
            issue(OP_STORE, st_f3[i], st_a[i], st_sd[i], 5'd0);
            ready_now(32'd0);
            step();
            chk("st_table_be", 32'(last_be), 32'(st_be[i]));
            chk("st_table_wdata", last_wdata, st_wd[i]);
            chk("st_table_no_wb", 32'(wb_cnt - b_wb), 32'd0);
        end

        // Timeout, then the next instruction is accepted during the bus_err cycle
        snap();
        issue(OP_LOAD, 3'd2, 32'h0000_4000, 32'd0, 5'd4);
        repeat (TMO) step();
        issue(OP_ALU, 3'd0, 32'h0000_0077, 32'd0, 5'd8);
        step();
        chk("tmo_req_cycles", 32'(req_cyc - b_req), 32'(TMO));
        chk("tmo_err_count", 32'(err_cnt - b_err), 32'd1);
        chk("tmo_wb_count", 32'(wb_cnt - b_wb), 32'd1);
        chk("tmo_next_wb", last_wb_data, 32'h0000_0077);

        // Reset in the middle of an access; a late ready is ignored
        snap();
        issue(OP_LOAD, 3'd2, 32'h0000_5000, 32'd0, 5'd10);
        step();
        r = 1;
        #1;
        chk("rmid_req", 32'(dmem_req), 32'd0);
        chk("rmid_stall", 32'(mem_stall), 32'd0);
        step();
        r = 0;
        step();
        ready_now(32'h1234_5678);
        step();
        chk("rmid_no_wb", 32'(wb_cnt - b_wb), 32'd0);
        chk("rmid_req_cycles", 32'(req_cyc - b_req), 32'd1);
        issue(OP_ALU, 3'd0, 32'h0000_0099, 32'd0, 5'd11);
        step();
        chk("rmid_idle_wb", 32'(wb_cnt - b_wb), 32'd1);
        chk("rmid_idle_data", last_wb_data, 32'h0000_0099);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
